// File: rtl/final_sprite_layer.sv
// rtl/final_sprite_layer.sv - scaled, animated palette sprite overlay on the VGA beam
// SPRITE_MIRROR_EN adds a frame-shadowed horizontal mirror input.
module final_sprite_layer #(
  parameter int IMG_W       = 32,
  parameter int IMG_H       = 32,
  parameter int FRAMES      = 4,
  parameter int SCALE_SHIFT = 1,
  parameter int ROM_LATENCY = 1,
  parameter int IDX_W       = 3,
  parameter int TRANSP_IDX  = 0,
  parameter int ANIM_DIV    = 8,
  localparam int ADDR_W     = $clog2(FRAMES * IMG_W * IMG_H)
) (
  input  logic              vga_clk,
  input  logic              reset_n,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  input  logic              blank,
  input  logic              frame_start,
  input  logic [9:0]        pos_x,
  input  logic [9:0]        pos_y,
  input  logic              anim_en,
`ifdef SPRITE_MIRROR_EN
  input  logic              mirror,
`endif
  input  logic [3:0]        bg_red,
  input  logic [3:0]        bg_green,
  input  logic [3:0]        bg_blue,
  output logic [ADDR_W-1:0] rom_address,
  input  logic [IDX_W-1:0]  rom_q,
  output logic [IDX_W-1:0]  pal_index,
  input  logic [11:0]       pal_rgb,
  output logic [3:0]        red,
  output logic [3:0]        green,
  output logic [3:0]        blue,
  output logic              hit
);

  localparam int DEPTH = ROM_LATENCY + 1;
  localparam int DIV_W = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
  localparam int FRM_W = (FRAMES > 1) ? $clog2(FRAMES) : 1;
  localparam logic [10:0] BOX_W = 11'(IMG_W << SCALE_SHIFT);
  localparam logic [10:0] BOX_H = 11'(IMG_H << SCALE_SHIFT);

  logic [9:0]       sh_x, sh_y;
  logic             sh_anim;
  logic [DIV_W-1:0] div_cnt;
  logic [FRM_W-1:0] frame;
`ifdef SPRITE_MIRROR_EN
  logic             sh_mirror;
`endif

  // Divider/frame advance on the anim_en shadowed by the previous frame_start.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      sh_x    <= '0;
      sh_y    <= '0;
      sh_anim <= 1'b0;
      div_cnt <= '0;
      frame   <= '0;
`ifdef SPRITE_MIRROR_EN
      sh_mirror <= 1'b0;
`endif
    end else if (frame_start) begin
      sh_x    <= pos_x;
      sh_y    <= pos_y;
      sh_anim <= anim_en;
`ifdef SPRITE_MIRROR_EN
      sh_mirror <= mirror;
`endif
      if (sh_anim) begin
        if (div_cnt == DIV_W'(ANIM_DIV - 1)) begin
          div_cnt <= '0;
          frame   <= (frame == FRM_W'(FRAMES - 1)) ? '0 : frame + 1'b1;
        end else begin
          div_cnt <= div_cnt + 1'b1;
        end
      end
    end
  end

  logic [10:0]       dx, dy, tx_raw, tx, ty;
  logic              in_box;
  logic [ADDR_W-1:0] addr_next;

  assign dx = {1'b0, DrawX} - {1'b0, sh_x};
  assign dy = {1'b0, DrawY} - {1'b0, sh_y};
  // Visible-area bounds clip sprites hanging off the right/bottom edge.
  assign in_box = !dx[10] && !dy[10] && (dx < BOX_W) && (dy < BOX_H) &&
                  (DrawX < 10'd640) && (DrawY < 10'd480);
  assign tx_raw = dx >> SCALE_SHIFT;
  assign ty     = dy >> SCALE_SHIFT;
`ifdef SPRITE_MIRROR_EN
  assign tx = sh_mirror ? (11'(IMG_W - 1) - tx_raw) : tx_raw;
`else
  assign tx = tx_raw;
`endif
  assign addr_next = ADDR_W'(frame) * ADDR_W'(IMG_W * IMG_H) +
                     ADDR_W'(ty) * ADDR_W'(IMG_W) + ADDR_W'(tx);

  logic [DEPTH-1:0] box_p, blank_p;
  logic [11:0]      bg_p [DEPTH];

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      rom_address <= '0;
      box_p       <= '0;
      blank_p     <= '0;
      for (int i = 0; i < DEPTH; i++) bg_p[i] <= '0;
    end else begin
      rom_address <= in_box ? addr_next : '0;
      box_p[0]    <= in_box;
      blank_p[0]  <= blank;
      bg_p[0]     <= {bg_red, bg_green, bg_blue};
      for (int i = 1; i < DEPTH; i++) begin
        box_p[i]   <= box_p[i-1];
        blank_p[i] <= blank_p[i-1];
        bg_p[i]    <= bg_p[i-1];
      end
    end
  end

  assign pal_index = rom_q;

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      {red, green, blue} <= '0;
      hit                <= 1'b0;
    end else if (!blank_p[DEPTH-1]) begin
      {red, green, blue} <= '0;
      hit                <= 1'b0;
    end else if (box_p[DEPTH-1] && (rom_q != IDX_W'(TRANSP_IDX))) begin
      {red, green, blue} <= pal_rgb;
      hit                <= 1'b1;
    end else begin
      {red, green, blue} <= bg_p[DEPTH-1];
      hit                <= 1'b0;
    end
  end

endmodule

// File: doc/final_sprite_layer.md
FINAL_SPRITE_LAYER -- requirements
Module: final_sprite_layer

Interface
REQ-001 SHALL have parameters: IMG_W, default 32, sprite width in texels.
REQ-002 SHALL have parameters: IMG_H, default 32, sprite height in texels.
REQ-003 SHALL have parameters: FRAMES, default 4, number of animation frames stored back-to-back in ROM.
REQ-004 SHALL have parameters: SCALE_SHIFT, default 1, on-screen pixels per texel = 2^SCALE_SHIFT per axis.
REQ-005 SHALL have parameters: ROM_LATENCY, default 1, read latency in cycles of the external ROM.
REQ-006 SHALL have parameters: IDX_W, default 3, palette index width.
REQ-007 SHALL have parameters: TRANSP_IDX, default 0, palette index rendered as transparent.
REQ-008 SHALL have parameters: ANIM_DIV, default 8, frame_start pulses per animation step.
REQ-009 SHALL have ports, in order: vga_clk in 1, sole clock; reset_n in 1, asynchronous active-low reset. One clock; reset is asynchronous and active-low.
REQ-010 SHALL have ports: DrawX in 10, DrawY in 10, current beam pixel; blank in 1, high = visible region.
REQ-011 SHALL have ports: frame_start in 1, single-cycle pulse once per frame, outside visible region.
REQ-012 SHALL have ports: pos_x in 10, pos_y in 10, anim_en in 1, requested sprite origin and animation enable.
REQ-013 SHALL have ports: bg_red, bg_green, bg_blue in 4 each, background colour for the same DrawX/DrawY.
REQ-014 SHALL have ports: rom_address out clog2(FRAMES*IMG_W*IMG_H); rom_q in IDX_W.
REQ-015 SHALL have ports: pal_index out IDX_W; pal_rgb in 12, combinational palette colour of pal_index ({r,g,b}).
REQ-016 SHALL have ports: red, green, blue out 4 each; hit out 1, opaque sprite pixel drawn.

Function
REQ-017 SHALL capture pos_x, pos_y, anim_en into shadow registers only in the cycle frame_start=1; mid-frame input changes SHALL NOT affect rendering.
REQ-018 SHALL keep a divider counter 0..ANIM_DIV-1, advanced on each frame_start while shadow anim_en=1; on wrap SHALL advance frame 0..FRAMES-1, wrapping FRAMES-1 -> 0.
REQ-019 SHALL hold divider and frame when anim_en=0; both SHALL use the shadow anim_en in effect before the capturing frame_start.
REQ-020 SHALL compute dx=DrawX-pos_x, dy=DrawY-pos_y in 11-bit arithmetic; in_box SHALL be 0<=dx<IMG_W<<SCALE_SHIFT and 0<=dy<IMG_H<<SCALE_SHIFT.
REQ-021 Sprites extending past column 639 or row 479 SHALL be clipped with no wrap.
REQ-022 SHALL register rom_address = frame*IMG_W*IMG_H + (dy>>SCALE_SHIFT)*IMG_W + (dx>>SCALE_SHIFT) at cycle T+1 for inputs sampled at T; when in_box=0, rom_address SHALL hold 0.
REQ-023 SHALL delay in_box, blank and bg colour through a pipeline aligned so rom_q (valid at T+1+ROM_LATENCY) meets them.
REQ-024 SHALL drive pal_index = rom_q combinationally.
REQ-025 SHALL register the output at T+2+ROM_LATENCY (total latency LAT=ROM_LATENCY+2) as follows:
- blank=0: output 0,0,0 and hit=0.
- in_box=1 and rom_q!=TRANSP_IDX: output pal_rgb and hit=1.
- Otherwise: output bg colour and hit=0.
REQ-026 SHALL sustain one pixel per cycle with no stalls.
REQ-027 ROM_LATENCY=0 SHALL be legal and give LAT=2.

Reset
REQ-028 While reset_n=0, SHALL hold red/green/blue/hit/rom_address at 0, shadow position 0, shadow anim_en 0, divider 0, frame 0, and all pipeline valid and blank bits 0.
REQ-029 Reset asserted mid-line SHALL take effect immediately.
REQ-030 After release, output SHALL be black until LAT cycles of fresh input have propagated.
REQ-031 frame_start coincident with reset_n=0 SHALL be ignored.

Configuration
REQ-032 With SPRITE_MIRROR_EN defined, SHALL add input mirror (1 bit), shadowed on frame_start like pos_x; when set, texel x = IMG_W-1-(dx>>SCALE_SHIFT).
REQ-033 Without SPRITE_MIRROR_EN, the mirror port SHALL be absent and texel x SHALL be unmirrored.

Verification
REQ-034 pos=(100,50), frame_start, defaults; DrawX=100, DrawY=50 at T -> rom_address=0 at T+1, output pal_rgb at T+3 with hit=1 if rom_q!=0.
REQ-035 Same position, DrawX=163, DrawY=113 -> rom_address=1023; DrawX=164 -> bg colour, hit=0.
REQ-036 rom_q=TRANSP_IDX inside box -> bg colour, hit=0; blank=0 inside box -> 0,0,0.
REQ-037 anim_en=1, 8 frame_start pulses -> frame=1, address base 1024; 32 pulses -> frame back to 0.
REQ-038 pos_x changed 100 -> 200 mid-frame -> no render change until next frame_start.
REQ-039 pos_x=620 -> columns 620..639 drawn, no wrap to column 0; reset mid-line -> outputs 0 same cycle.
